// File: rtl/lzc_pipe.sv
// rtl/lzc_pipe.sv - pipelined leading/trailing zero counter with normaliser
//
// Purpose:
//   Counts the zeros above the highest set bit (leading mode) or below the
//   lowest set bit (trailing mode) of a WIDTH-bit operand, and returns the
//   operand shifted so that its first set bit sits at the MSB (leading) or
//   LSB (trailing). The work is spread over NUM_STAGES elastic register
//   stages with a valid/ready handshake at both ends.
//
// Ports:
//   clk_i    in   1          clock, rising edge
//   rst_i    in   1          synchronous active-high reset
//   valid_i  in   1          operand valid
//   ready_o  out  1          operand accepted this cycle when valid_i is high
//   data_i   in   WIDTH      operand
//   mode_i   in   1          0: trailing-zero count, 1: leading-zero count
//   valid_o  out  1          result valid
//   ready_i  in   1          downstream accepts the result
//   cnt_o    out  CNT_WIDTH  zero count (WIDTH-1 for an all-zero operand,
//                            1 when WIDTH is 1)
//   norm_o   out  WIDTH      normalised operand (0 for an all-zero operand)
//   empty_o  out  1          operand was all zeros
//   mode_o   out  1          mode that travelled with this result

module lzc_pipe #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned NUM_STAGES = 2,
  parameter int unsigned CNT_WIDTH  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [WIDTH-1:0]     data_i,
  input  logic                 mode_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic [WIDTH-1:0]     norm_o,
  output logic                 empty_o,
  output logic                 mode_o
);

  localparam int unsigned LAST = NUM_STAGES - 1;

  // An all-zero operand reports WIDTH-1; the single-bit operand is the odd
  // one out, where the count is simply the inverted bit.
  localparam logic [CNT_WIDTH-1:0] EMPTY_CNT =
    (WIDTH == 1) ? CNT_WIDTH'(1) : CNT_WIDTH'(WIDTH - 1);

  // Priority encode the first set bit seen from the chosen end. The scan
  // runs towards that end so the last hit wins and gives the nearest bit.
  function automatic logic [CNT_WIDTH-1:0] zero_count(
    input logic [WIDTH-1:0] d,
    input logic             lead
  );
    logic [CNT_WIDTH-1:0] c;
    c = EMPTY_CNT;
    if (lead) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (d[i]) c = CNT_WIDTH'(int'(WIDTH) - 1 - i);
      end
    end else begin
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
        if (d[i]) c = CNT_WIDTH'(i);
      end
    end
    return c;
  endfunction

  // A zero operand shifts to zero on its own, so no special case is needed.
  function automatic logic [WIDTH-1:0] normalise(
    input logic [WIDTH-1:0]     d,
    input logic [CNT_WIDTH-1:0] c,
    input logic                 lead
  );
    return lead ? (d << c) : (d >> c);
  endfunction

  // Stage registers. Before the last stage data_q carries the raw operand;
  // the last stage holds the shifted operand, so the count tree sits in
  // front of stage 0 and the shifter in front of the last stage.
  logic [NUM_STAGES-1:0] valid_q;
  logic [WIDTH-1:0]      data_q  [NUM_STAGES];
  logic [CNT_WIDTH-1:0]  cnt_q   [NUM_STAGES];
  logic [NUM_STAGES-1:0] empty_q;
  logic [NUM_STAGES-1:0] mode_q;

  // Values presented to each stage by its upstream neighbour.
  logic [NUM_STAGES-1:0] src_valid;
  logic [WIDTH-1:0]      src_data [NUM_STAGES];
  logic [CNT_WIDTH-1:0]  src_cnt  [NUM_STAGES];
  logic [NUM_STAGES-1:0] src_empty;
  logic [NUM_STAGES-1:0] src_mode;
  logic [WIDTH-1:0]      ld_data  [NUM_STAGES];

  logic [NUM_STAGES-1:0] stage_ready;
  logic [NUM_STAGES-1:0] stage_load;

  always_comb begin
    src_valid   = '0;
    src_empty   = '0;
    src_mode    = '0;
    src_data    = '{default: '0};
    src_cnt     = '{default: '0};
    ld_data     = '{default: '0};
    stage_ready = '0;
    stage_load  = '0;

    src_valid[0] = valid_i;
    src_data[0]  = data_i;
    src_mode[0]  = mode_i;
    src_cnt[0]   = zero_count(data_i, mode_i);
    src_empty[0] = ~|data_i;

    for (int k = 1; k < int'(NUM_STAGES); k++) begin
      src_valid[k] = valid_q[k-1];
      src_data[k]  = data_q[k-1];
      src_mode[k]  = mode_q[k-1];
      src_cnt[k]   = cnt_q[k-1];
      src_empty[k] = empty_q[k-1];
    end

    for (int k = 0; k < int'(NUM_STAGES); k++) begin
      if (k == int'(LAST)) begin
        ld_data[k] = normalise(src_data[k], src_cnt[k], src_mode[k]);
      end else begin
        ld_data[k] = src_data[k];
      end
    end

    // A stage can take new contents when it or any stage after it has a
    // hole, or when the sink drains the last stage. This is the unrolled
    // form of ready_k = !valid_k || ready_(k+1).
    for (int k = 0; k < int'(NUM_STAGES); k++) begin
      stage_ready[k] = ready_i;
      for (int j = k; j < int'(NUM_STAGES); j++) begin
        if (!valid_q[j]) stage_ready[k] = 1'b1;
      end
      stage_load[k] = src_valid[k] && stage_ready[k];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      empty_q <= '0;
      mode_q  <= '0;
      for (int k = 0; k < int'(NUM_STAGES); k++) begin
        data_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < int'(NUM_STAGES); k++) begin
        // When the stage is free to move, its valid bit follows upstream;
        // otherwise it holds so a stalled result stays put.
        if (stage_ready[k]) valid_q[k] <= src_valid[k];
        // Payload only changes on a real load, keeping outputs stable
        // while a result waits for the sink.
        if (stage_load[k]) begin
          data_q[k]  <= ld_data[k];
          cnt_q[k]   <= src_cnt[k];
          empty_q[k] <= src_empty[k];
          mode_q[k]  <= src_mode[k];
        end
      end
    end
  end

  assign ready_o = stage_ready[0];
  assign valid_o = valid_q[LAST];
  assign cnt_o   = cnt_q[LAST];
  assign norm_o  = data_q[LAST];
  assign empty_o = empty_q[LAST];
  assign mode_o  = mode_q[LAST];

endmodule

// File: tb/tb_lzc_pipe.sv
// tb/tb_lzc_pipe.sv - directed self-checking bench for lzc_pipe
//
// Three instances: WIDTH=8/NUM_STAGES=2 (main), WIDTH=1 and WIDTH=7.
// Inputs change 1 time unit after a rising edge; outputs are sampled on
// the falling edge.

module tb_lzc_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic       a_valid_i, a_ready_o, a_mode_i, a_valid_o, a_ready_i;
  logic       a_empty_o, a_mode_o;
  logic [7:0] a_data_i, a_norm_o;
  logic [2:0] a_cnt_o;

  logic       b_valid_i, b_ready_o, b_mode_i, b_valid_o, b_ready_i;
  logic       b_empty_o, b_mode_o;
  logic [0:0] b_data_i, b_norm_o, b_cnt_o;

  logic       c_valid_i, c_ready_o, c_mode_i, c_valid_o, c_ready_i;
  logic       c_empty_o, c_mode_o;
  logic [6:0] c_data_i, c_norm_o;
  logic [2:0] c_cnt_o;

  lzc_pipe #(.WIDTH(8), .NUM_STAGES(2)) dut_a (
    .clk_i(clk), .rst_i(rst), .valid_i(a_valid_i), .ready_o(a_ready_o),
    .data_i(a_data_i), .mode_i(a_mode_i), .valid_o(a_valid_o),
    .ready_i(a_ready_i), .cnt_o(a_cnt_o), .norm_o(a_norm_o),
    .empty_o(a_empty_o), .mode_o(a_mode_o)
  );

  lzc_pipe #(.WIDTH(1), .NUM_STAGES(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .valid_i(b_valid_i), .ready_o(b_ready_o),
    .data_i(b_data_i), .mode_i(b_mode_i), .valid_o(b_valid_o),
    .ready_i(b_ready_i), .cnt_o(b_cnt_o), .norm_o(b_norm_o),
    .empty_o(b_empty_o), .mode_o(b_mode_o)
  );

  lzc_pipe #(.WIDTH(7), .NUM_STAGES(2)) dut_c (
    .clk_i(clk), .rst_i(rst), .valid_i(c_valid_i), .ready_o(c_ready_o),
    .data_i(c_data_i), .mode_i(c_mode_i), .valid_o(c_valid_o),
    .ready_i(c_ready_i), .cnt_o(c_cnt_o), .norm_o(c_norm_o),
    .empty_o(c_empty_o), .mode_o(c_mode_o)
  );

  // Reference model for the 8-bit instance: walk from the chosen end and
  // count zeros until the first one.
  function automatic logic [2:0] m_cnt(input logic [7:0] d, input logic lead);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    if (d == 8'h00) return 3'd7;
    for (int i = 0; i < 8; i++) begin
      if (!seen && !d[lead ? 7 - i : i]) n++;
      else seen = 1'b1;
    end
    return 3'(n);
  endfunction

  function automatic logic [7:0] m_norm(input logic [7:0] d, input logic lead);
    logic [2:0] c;
    c = m_cnt(d, lead);
    if (d == 8'h00) return 8'h00;
    return lead ? (d << c) : (d >> c);
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_valid_o, a_cnt_o, a_norm_o, a_empty_o, a_mode_o} !== 14'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 0",
               {a_valid_o, a_cnt_o, a_norm_o, a_empty_o, a_mode_o});
    end
    checks++;
    if (a_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b exp 1", a_ready_o);
    end
    checks++;
    if ({b_valid_o, c_valid_o, b_ready_o, c_ready_o} !== 4'b0011) begin
      errors++;
      $display("FAIL reset_degenerate got %b exp 0011",
               {b_valid_o, c_valid_o, b_ready_o, c_ready_o});
    end
  endtask

  task automatic test_basic;
    logic [7:0]  td [2] = '{8'h10, 8'h10};
    logic        tm [2] = '{1'b1, 1'b0};
    logic [13:0] te [2] = '{{1'b1, 3'd3, 8'h80, 1'b0, 1'b1},
                            {1'b1, 3'd4, 8'h01, 1'b0, 1'b0}};
    a_ready_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1 a_valid_i = 1'b1; a_data_i = td[i]; a_mode_i = tm[i];
      @(negedge clk);
      checks++;
      if (a_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL basic_ready[%0d] got %b exp 1", i, a_ready_o);
      end
      @(posedge clk);
      #1 a_valid_i = 1'b0;
      @(negedge clk);
      checks++;
      if (a_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL basic_early_valid[%0d] got %b exp 0", i, a_valid_o);
      end
      @(negedge clk);
      checks++;
      if ({a_valid_o, a_cnt_o, a_norm_o, a_empty_o, a_mode_o} !== te[i]) begin
        errors++;
        $display("FAIL basic_result[%0d] got %h exp %h", i,
                 {a_valid_o, a_cnt_o, a_norm_o, a_empty_o, a_mode_o}, te[i]);
      end
    end
  endtask

  task automatic test_boundaries;
    logic [7:0]  td [6] = '{8'h00, 8'h00, 8'h80, 8'h80, 8'h01, 8'h01};
    logic        tm [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [13:0] te [6] = '{{1'b1, 3'd7, 8'h00, 1'b1, 1'b1},
                            {1'b1, 3'd7, 8'h00, 1'b1, 1'b0},
                            {1'b1, 3'd0, 8'h80, 1'b0, 1'b1},
                            {1'b1, 3'd7, 8'h01, 1'b0, 1'b0},
                            {1'b1, 3'd7, 8'h80, 1'b0, 1'b1},
                            {1'b1, 3'd0, 8'h01, 1'b0, 1'b0}};
    a_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 a_valid_i = 1'b1; a_data_i = td[i]; a_mode_i = tm[i];
      @(posedge clk);
      #1 a_valid_i = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({a_valid_o, a_cnt_o, a_norm_o, a_empty_o, a_mode_o} !== te[i]) begin
        errors++;
        $display("FAIL boundary[%0d] got %h exp %h", i,
                 {a_valid_o, a_cnt_o, a_norm_o, a_empty_o, a_mode_o}, te[i]);
      end
    end
  endtask

  task automatic test_streaming;
    logic [7:0] sd [16];
    int got = 0;
    int gaps = 0;
    int last_cyc = 0;
    for (int i = 0; i < 16; i++) sd[i] = 8'($urandom);
    sd[3] = 8'h00;
    a_ready_i = 1'b1;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          @(posedge clk);
          #1 a_valid_i = 1'b1; a_data_i = sd[i]; a_mode_i = i[0];
        end
        @(posedge clk);
        #1 a_valid_i = 1'b0;
      end
      begin
        for (int c = 0; c < 40 && got < 16; c++) begin
          @(negedge clk);
          if (a_valid_o) begin
            if (got > 0 && c != last_cyc + 1) gaps++;
            last_cyc = c;
            checks++;
            if ({a_cnt_o, a_norm_o, a_empty_o, a_mode_o} !==
                {m_cnt(sd[got], got[0]), m_norm(sd[got], got[0]),
                 sd[got] == 8'h00, got[0]}) begin
              errors++;
              $display("FAIL stream[%0d] got %h exp %h", got,
                       {a_cnt_o, a_norm_o, a_empty_o, a_mode_o},
                       {m_cnt(sd[got], got[0]), m_norm(sd[got], got[0]),
                        sd[got] == 8'h00, got[0]});
            end
            got++;
          end
        end
      end
    join
    checks++;
    if (got != 16) begin
      errors++;
      $display("FAIL stream_count got %0d exp 16", got);
    end
    checks++;
    if (gaps != 0) begin
      errors++;
      $display("FAIL stream_gaps got %0d exp 0", gaps);
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] bp [3] = '{8'h3C, 8'h05, 8'hA0};
    logic       bm [3] = '{1'b1, 1'b0, 1'b1};
    int idx = 0;
    int got = 0;
    repeat (2) @(posedge clk);
    #1 a_ready_i = 1'b0; a_valid_i = 1'b1; a_data_i = bp[0]; a_mode_i = bm[0];
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      checks++;
      if (a_ready_o !== (cyc < 2)) begin
        errors++;
        $display("FAIL bp_ready[%0d] got %b exp %b", cyc, a_ready_o, cyc < 2);
      end
      if (cyc >= 2) begin
        checks++;
        if ({a_valid_o, a_cnt_o, a_norm_o, a_mode_o} !==
            {1'b1, m_cnt(bp[0], bm[0]), m_norm(bp[0], bm[0]), bm[0]}) begin
          errors++;
          $display("FAIL bp_hold[%0d] got %h exp %h", cyc,
                   {a_valid_o, a_cnt_o, a_norm_o, a_mode_o},
                   {1'b1, m_cnt(bp[0], bm[0]), m_norm(bp[0], bm[0]), bm[0]});
        end
      end
      if (a_ready_o) idx++;
      @(posedge clk);
      #1 a_data_i = bp[idx > 2 ? 2 : idx]; a_mode_i = bm[idx > 2 ? 2 : idx];
    end
    checks++;
    if (idx != 2) begin
      errors++;
      $display("FAIL bp_accepted got %0d exp 2", idx);
    end
    a_ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if (a_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready got %b exp 1", a_ready_o);
    end
    for (int c = 0; c < 9; c++) begin
      if (c > 0) @(negedge clk);
      if (a_valid_o) begin
        if (got < 3) begin
          checks++;
          if ({a_cnt_o, a_norm_o, a_mode_o} !==
              {m_cnt(bp[got], bm[got]), m_norm(bp[got], bm[got]), bm[got]}) begin
            errors++;
            $display("FAIL bp_order[%0d] got %h exp %h", got,
                     {a_cnt_o, a_norm_o, a_mode_o},
                     {m_cnt(bp[got], bm[got]), m_norm(bp[got], bm[got]), bm[got]});
          end
        end
        got++;
      end
      if (c == 0) begin
        @(posedge clk);
        #1 a_valid_i = 1'b0;
      end
    end
    checks++;
    if (got != 3) begin
      errors++;
      $display("FAIL bp_total got %0d exp 3", got);
    end
  endtask

  task automatic test_reset_mid;
    int seen = 0;
    @(posedge clk);
    #1 a_ready_i = 1'b0; a_valid_i = 1'b1; a_data_i = 8'h10; a_mode_i = 1'b1;
    @(posedge clk);
    #1 a_data_i = 8'h22; a_mode_i = 1'b0;
    @(posedge clk);
    #1 a_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_valid_o, a_ready_o} !== 2'b10) begin
      errors++;
      $display("FAIL mid_full got %b exp 10", {a_valid_o, a_ready_o});
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_valid_o, a_ready_o, a_cnt_o, a_norm_o, a_empty_o, a_mode_o} !== 15'h2000) begin
      errors++;
      $display("FAIL mid_reset got %h exp 2000",
               {a_valid_o, a_ready_o, a_cnt_o, a_norm_o, a_empty_o, a_mode_o});
    end
    a_ready_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (a_valid_o) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL mid_flushed got %0d exp 0", seen);
    end
  endtask

  task automatic test_degenerate;
    logic [0:0]  bd [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic        bmd [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [4:0]  be [4] = '{{1'b1, 1'b1, 1'b0, 1'b1, 1'b1},
                            {1'b1, 1'b0, 1'b1, 1'b0, 1'b0},
                            {1'b1, 1'b0, 1'b1, 1'b0, 1'b1},
                            {1'b1, 1'b1, 1'b0, 1'b1, 1'b0}};
    logic [6:0]  cd [4] = '{7'h00, 7'h01, 7'h40, 7'h08};
    logic        cmd [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [12:0] ce [4] = '{{1'b1, 3'd6, 7'h00, 1'b1, 1'b1},
                            {1'b1, 3'd6, 7'h40, 1'b0, 1'b1},
                            {1'b1, 3'd6, 7'h01, 1'b0, 1'b0},
                            {1'b1, 3'd3, 7'h40, 1'b0, 1'b1}};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 b_valid_i = 1'b1; b_data_i = bd[i]; b_mode_i = bmd[i];
      c_valid_i = 1'b1; c_data_i = cd[i]; c_mode_i = cmd[i];
      @(posedge clk);
      #1 b_valid_i = 1'b0; c_valid_i = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({b_valid_o, b_cnt_o, b_norm_o, b_empty_o, b_mode_o} !== be[i]) begin
        errors++;
        $display("FAIL w1[%0d] got %b exp %b", i,
                 {b_valid_o, b_cnt_o, b_norm_o, b_empty_o, b_mode_o}, be[i]);
      end
      checks++;
      if ({c_valid_o, c_cnt_o, c_norm_o, c_empty_o, c_mode_o} !== ce[i]) begin
        errors++;
        $display("FAIL w7[%0d] got %h exp %h", i,
                 {c_valid_o, c_cnt_o, c_norm_o, c_empty_o, c_mode_o}, ce[i]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    a_valid_i = 1'b0; a_data_i = '0; a_mode_i = 1'b0; a_ready_i = 1'b1;
    b_valid_i = 1'b0; b_data_i = '0; b_mode_i = 1'b0; b_ready_i = 1'b1;
    c_valid_i = 1'b0; c_data_i = '0; c_mode_i = 1'b0; c_ready_i = 1'b1;
    test_reset();
    test_basic();
    test_boundaries();
    test_streaming();
    test_backpressure();
    test_reset_mid();
    test_degenerate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lzc_pipe.md
# lzc_pipe

Pipelined, runtime-selectable leading/trailing zero counter with normaliser and valid/ready handshake. It counts the zeros from the MSB (leading) or LSB (trailing) of a WIDTH-bit operand. It also returns the operand shifted so that its first set bit lands at the MSB or LSB. It sits in the posit decode/normalise path as the elastic replacement for the purely combinational zero counter, so the count and the shift can be retimed across NUM_STAGES register stages.

## Interface
Parameters:
- WIDTH, 32, operand width; WIDTH >= 1.
- NUM_STAGES, 2, number of register stages between input and output; 1..4.
- CNT_WIDTH, cf_math_pkg::idx_width(WIDTH), dependent; do not override.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- valid_i  in  1  input operand valid.
- ready_o  out  1  block accepts the operand this cycle.
- data_i  in  WIDTH  operand.
- mode_i  in  1  0: trailing-zero count, 1: leading-zero count; sampled with the operand.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts the result.
- cnt_o  out  CNT_WIDTH  zero count.
- norm_o  out  WIDTH  normalised operand.
- empty_o  out  1  operand was all zeros.
- mode_o  out  1  mode_i that travelled with this result.

## Operation
- Count:
  - Leading mode: cnt = number of zeros above the highest set bit.
  - Trailing mode: cnt = number of zeros below the lowest set bit.
- Normalise:
  - Leading mode: norm = data << cnt, so norm[WIDTH-1] = 1.
  - Trailing mode: norm = data >> cnt, so norm[0] = 1.
  - Vacated bits are zero. Shift width is CNT_WIDTH. Result is truncated to WIDTH.
- Empty operand (data == 0):
  - empty_o = 1.
  - cnt_o = WIDTH-1 (maximum count minus one).
  - norm_o = 0.
- WIDTH == 1 (degenerate case):
  - cnt_o = ~data[0]; empty_o = ~data[0]; norm_o = data.
  - Pipeline and handshake are unchanged.
- Pipeline:
  - NUM_STAGES elastic stages. Each stage holds a valid bit plus payload (partial count/shift state, mode).
  - A stage loads when its upstream is valid and it is either empty or its own contents are leaving this cycle.
  - Stage k holds its contents while valid_k && !ready_(k+1).
- The split of the counter tree and shifter across stages is an implementation choice. All outputs must come straight from the last stage registers; no combinational path from data_i or mode_i to any output.
- Handshake:
  - Transfer at the input when valid_i && ready_o. Transfer at the output when valid_o && ready_i.
  - ready_o may depend combinationally on ready_i. valid_o must not depend on ready_i.
  - Once valid_o is asserted, valid_o and all payload outputs stay stable until the output transfer.
  - Results leave in acceptance order. None are dropped or duplicated.
- Reset: every stage valid bit and payload register clears to 0.

## Timing
- Reset values:
  - valid_o = 0, cnt_o = 0, norm_o = 0, empty_o = 0, mode_o = 0.
  - ready_o = 1 in the first cycle after reset deasserts.
  - Reset takes priority over any simultaneous transfer.
- Latency:
  - An operand accepted at edge t shows on the outputs after edge t+NUM_STAGES-1, i.e. valid in cycle t+NUM_STAGES, when ready_i has been held high.
- Throughput: 1 operand/cycle with ready_i held high. Back-to-back operands with different modes are supported.
- Full condition:
  - With ready_i low, the block accepts exactly NUM_STAGES operands.
  - ready_o then goes low in the same cycle the last stage fills and stays low while ready_i is low.
- Simultaneous events:
  - With the pipe full, an output transfer and an input transfer in the same cycle are both accepted (ready_o = ready_i); occupancy is unchanged.
- Reset mid-operation: all in-flight operands are discarded. The cycle after reset deasserts has valid_o = 0 and ready_o = 1.

## Test plan
- Basic (WIDTH=8, NUM_STAGES=2):
  - data 0x10, mode 1 -> cnt 3, norm 0x80, empty 0, mode_o 1, valid_o two cycles after acceptance.
  - Same data, mode 0 -> cnt 4, norm 0x01.
- Boundaries (WIDTH=8):
  - 0x00 -> empty 1, cnt 7, norm 0x00 in both modes.
  - 0x80 leading -> cnt 0, norm 0x80.
  - 0x80 trailing -> cnt 7, norm 0x01.
  - 0x01 leading -> cnt 7, norm 0x80.
- Streaming: 16 back-to-back random operands with alternating mode and ready_i high -> 16 results in order against a reference model; valid_o high 16 consecutive cycles.
- Backpressure:
  - ready_i low for 5 cycles while valid_i held high -> exactly 2 operands accepted, then ready_o low; outputs stable throughout.
  - Raise ready_i -> ready_o high the same cycle; no loss or duplication.
- Reset mid-stream: assert rst_i for 1 cycle with the pipe full -> next cycle valid_o 0, ready_o 1, all payload outputs 0; flushed operands never appear.
- Degenerate WIDTH=1 and WIDTH=7:
  - WIDTH=1: data 0 -> empty 1, cnt 1; data 1 -> cnt 0, norm 1.
  - WIDTH=7: data 0 -> cnt 6.
